// File: rtl/n64_vinfo_ext_if.sv
// N64 digital video bus as seen by passive observers of the VCLK domain.
// Observer-only bus: there is no ready; every VCLK edge with nVDSYNC low is a sync sample.
interface n64_vinfo_ext_if;
  logic       nVDSYNC;
  logic [6:0] D_i;

  modport master (output nVDSYNC, output D_i);
  modport slave  (input  nVDSYNC, input  D_i);
endinterface

// File: rtl/n64_vinfo_ext.sv
// Video-format extraction for the N64 bus: pixel phase, PAL/NTSC line-count mode
// and interlace detection from consecutive field line counts.
module n64_vinfo_ext #(
  parameter int LINE_CNT_W      = 10,
  parameter int PAL_LINE_THRESH = 288
) (
  input  logic           VCLK,
  input  logic           nRST,
  n64_vinfo_ext_if.slave vbus,
  output logic [1:0]     data_cnt,
  output logic           vmode,
  output logic           n64_480i,
  output logic           vinfo_valid
);

  localparam logic [LINE_CNT_W-1:0] LINE_MAX   = '1;
  localparam logic [LINE_CNT_W-1:0] LINE_ONE   = LINE_CNT_W'(1);
  localparam logic [LINE_CNT_W-1:0] PAL_THRESH = LINE_CNT_W'(PAL_LINE_THRESH);

  logic [1:0]            data_cnt_q, data_cnt_d;
  logic                  hs_q, hs_d, vs_q, vs_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_CNT_W-1:0] prev_cnt_q, prev_cnt_d;
  logic [1:0]            fields_q, fields_d;
  logic                  vmode_q, vmode_d;
  logic                  i480_q, i480_d;
  logic                  valid_q, valid_d;

  logic sync_s, hs_fall, vs_fall;

  assign sync_s  = ~vbus.nVDSYNC;
  assign hs_fall = sync_s & ~vbus.D_i[1] & hs_q;
  assign vs_fall = sync_s & ~vbus.D_i[3] & vs_q;

  always_comb begin
    data_cnt_d = sync_s ? 2'd1 : data_cnt_q + 2'd1;
    hs_d       = sync_s ? vbus.D_i[1] : hs_q;
    vs_d       = sync_s ? vbus.D_i[3] : vs_q;
    line_cnt_d = line_cnt_q;
    prev_cnt_d = prev_cnt_q;
    fields_d   = fields_q;
    vmode_d    = vmode_q;
    i480_d     = i480_q;
    valid_d    = valid_q;

    if (vs_fall) begin
      // A coincident HS fall opens the new field, so the closing count excludes it.
      prev_cnt_d = line_cnt_q;
      line_cnt_d = hs_fall ? LINE_ONE : '0;
      if (fields_q != 2'd3) fields_d = fields_q + 2'd1;
      if (fields_q >= 2'd1) vmode_d = (line_cnt_q >= PAL_THRESH);
      if (fields_q >= 2'd2) begin
        i480_d  = (line_cnt_q != prev_cnt_q);
        valid_d = 1'b1;
      end
    end else if (hs_fall && (line_cnt_q != LINE_MAX)) begin
      line_cnt_d = line_cnt_q + LINE_ONE;
    end

    // A saturated line count means VSYNC was lost: restart measurement, keep last mode flags.
    if (line_cnt_d == LINE_MAX) begin
      valid_d  = 1'b0;
      fields_d = 2'd0;
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      data_cnt_q <= 2'd0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      line_cnt_q <= '0;
      prev_cnt_q <= '0;
      fields_q   <= 2'd0;
      vmode_q    <= 1'b0;
      i480_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      data_cnt_q <= data_cnt_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      line_cnt_q <= line_cnt_d;
      prev_cnt_q <= prev_cnt_d;
      fields_q   <= fields_d;
      vmode_q    <= vmode_d;
      i480_q     <= i480_d;
      valid_q    <= valid_d;
    end
  end

  assign data_cnt    = data_cnt_q;
  assign vmode       = vmode_q;
  assign n64_480i    = i480_q;
  assign vinfo_valid = valid_q;

endmodule

// File: doc/n64_vinfo_ext.md
# n64_vinfo_ext

Extracts video-format information from the N64 digital video bus: pixel-phase counter, PAL/NTSC line-count mode, and interlace (480i) detection. Sits upstream of the controller housekeeping stage and drives its `n64_480i` input. It also feeds the pixel-phase count and mode flags to the downstream video pipeline. Pure observer of the VCLK-domain bus; no back-pressure.

## Interface
Parameters:
- `LINE_CNT_W`, 10: width of the line counter. Saturates at 2^W−1 (1023).
- `PAL_LINE_THRESH`, 288: a complete field with ≥ this many lines is PAL.

Ports:
- `VCLK`  in  1  video clock (~48.7/49.7 MHz); single clock domain.
- `nRST`  in  1  reset, asynchronous, active-low.
- `nVDSYNC`  in  1  low marks the sync byte on `D_i`.
- `D_i`  in  7  video bus. In a sync byte: [3]=nVSYNC, [2]=nCLAMP, [1]=nHSYNC, [0]=nCSYNC.
- `data_cnt`  out  2  pixel-phase counter (0 = sync byte phase).
- `vmode`  out  1  1 = PAL (≥ `PAL_LINE_THRESH` lines/field), 0 = NTSC.
- `n64_480i`  out  1  1 = interlaced (line count alternates between fields).
- `vinfo_valid`  out  1  1 = two consecutive complete fields measured, outputs trustworthy.

## Operation
- **Phase counter.** At each VCLK rising edge:
  - if `nVDSYNC`=0, `data_cnt` ← 1;
  - else `data_cnt` ← `data_cnt`+1 (wraps 3→0).
- **Sync capture.** On edges with `nVDSYNC`=0, register `hs_q`←D_i[1] and `vs_q`←D_i[3]. Edges with `nVDSYNC`=1 leave them unchanged.
  - HS falling = sync sample with D_i[1]=0 while `hs_q`=1.
  - VS falling = sync sample with D_i[3]=0 while `vs_q`=1.
- **Line counter `line_cnt`.** Counts HS falls and saturates at 1023.
- **Field counter `fields_seen`.** 2 bits, saturating at 3.
- **On VS fall:**
  - `prev_cnt` ← `line_cnt`.
  - `line_cnt` ← 1 if HS fall occurs in the same sample, else 0.
  - `fields_seen` ← min(`fields_seen`+1, 3).
  - If `fields_seen` ≥ 1 (closing field is complete): `vmode` ← (`line_cnt` ≥ `PAL_LINE_THRESH`).
  - If `fields_seen` ≥ 2: `n64_480i` ← (`line_cnt` ≠ `prev_cnt`), and `vinfo_valid` ← 1.
- **Simultaneous HS and VS fall.** The HS belongs to the new field. The compared count excludes it.
- **Timeout.** When `line_cnt` reaches 1023 (no VS for ~1023 lines):
  - `vinfo_valid` ← 0 and `fields_seen` ← 0;
  - `vmode` and `n64_480i` hold their last values;
  - the first VS fall afterwards restarts measurement as if from reset.
- **First field.** The partial field before the first VS fall is never evaluated.

## Timing
- All outputs are registered.
- Updates triggered by a sample at edge k are visible immediately after edge k. Latency is one VCLK from the sampling edge.
- `vmode` is valid after the 2nd VS fall.
- `n64_480i` and `vinfo_valid` are valid after the 3rd VS fall.
- On `nRST`=0, asynchronously and independent of VCLK:
  - `data_cnt`=0, `vmode`=0, `n64_480i`=0, `vinfo_valid`=0;
  - `line_cnt`=0, `prev_cnt`=0, `fields_seen`=0;
  - `hs_q`=1, `vs_q`=1.
- Reset mid-field discards all measurement. After release, behaviour is identical to power-up.
- `nVDSYNC` held low for several cycles: `data_cnt` stays 1, and each such cycle is a sync sample. Edge detection is level-history based, so repeated low samples do not double-count.

## Test plan
- **Reset.** Assert `nRST` mid-frame with outputs set (PAL, 480i, valid) -> all outputs 0 asynchronously before the next VCLK edge. After release, valid stays 0 until 3 VS falls.
- **Phase counter.** Single-cycle `nVDSYNC` low every 4 cycles -> `data_cnt` sequence 1,2,3,0,1,… Sync pulse after 2 cycles -> `data_cnt` forced to 1.
- **NTSC progressive.** 4 fields of 263 lines -> after 2nd VS: `vmode`=0. After 3rd VS: `n64_480i`=0, `vinfo_valid`=1.
- **NTSC interlaced.** Fields alternating 262/263 -> after 3rd VS: `n64_480i`=1, `vmode`=0, `vinfo_valid`=1.
- **PAL interlaced, with simultaneous HS+VS fall.** Fields 312/313 with HS falling in the same sync sample as VS -> `vmode`=1, `n64_480i`=1. New field `line_cnt` starts at 1.
- **Timeout.** After valid, send 1100 HS falls with no VS -> `vinfo_valid` drops at the 1023rd HS fall, `vmode`/`n64_480i` held. Resume 263-line fields -> valid again at the 3rd VS fall.
